// File: rtl/tone_pkg.sv
// Shared types and helpers for the multi-channel tone generator.
// Divisors travel zero-extended to MAX_DW bits so one record type serves every DW.
package tone_pkg;

    localparam int MAX_DW = 32;
    localparam logic [MAX_DW-1:0] MIN_DIV = 32'd2;

    typedef struct packed {
        logic [MAX_DW-1:0] div;
        logic              en;
    } tone_cfg_t;

    // High length of a period of d cycles, one bit wider so d = all-ones cannot wrap.
    function automatic logic [MAX_DW:0] half_len(input logic [MAX_DW-1:0] d);
        logic [MAX_DW:0] sum;
        sum = {1'b0, d} + 33'd1;
        return sum >> 1;
    endfunction

endpackage

// File: rtl/tone_chan.sv
// One tone channel: period counter, registered square wave and a one-deep
// pending configuration slot that is applied only at a period boundary.
module tone_chan
    import tone_pkg::*;
#(
    parameter int DW = 16
)
(
    input  logic      clk,
    input  logic      rst,
    input  logic      wr,
    input  tone_cfg_t wr_cfg,
    output logic      pend_v,
    output logic      tone,
    output logic      active
);

    tone_cfg_t         pend_r;
    logic              pend_v_r;
    logic              en_r;
    logic [MAX_DW-1:0] div_r;
    logic [DW-1:0]     cnt_r;
    logic              tone_r;
    logic              active_r;

    logic [MAX_DW-1:0] cnt_ext_s;
    logic [MAX_DW-1:0] cnt_next_ext_s;
    logic [DW-1:0]     cnt_next_s;
    logic              wrap_s;
    logic              running_s;
    logic              apply_s;
    logic              new_active_s;
    logic              tone_next_s;

    // Period-end detection, apply decision and next count/tone while running.
    always_comb begin
        cnt_ext_s           = '0;
        cnt_ext_s[DW-1:0]   = cnt_r;
        wrap_s              = (cnt_ext_s == (div_r - 32'd1));
        running_s           = en_r && (div_r >= MIN_DIV);
        apply_s             = pend_v_r && (!running_s || wrap_s);
        new_active_s        = pend_r.en && (pend_r.div >= MIN_DIV);
        if (wrap_s) begin
            cnt_next_s = '0;
        end else begin
            cnt_next_s = cnt_r + DW'(1'b1);
        end
        cnt_next_ext_s          = '0;
        cnt_next_ext_s[DW-1:0]  = cnt_next_s;
        tone_next_s             = ({1'b0, cnt_next_ext_s} < half_len(div_r));
    end

    // Pending slot, applied configuration, counter and tone registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_r   <= '0;
            pend_v_r <= 1'b0;
            en_r     <= 1'b0;
            div_r    <= '0;
            cnt_r    <= '0;
            tone_r   <= 1'b0;
            active_r <= 1'b0;
        end else begin
            // Accept and apply never coincide: wr is only raised while the slot is empty.
            if (wr) begin
                pend_r   <= wr_cfg;
                pend_v_r <= 1'b1;
            end else if (apply_s) begin
                pend_v_r <= 1'b0;
            end else begin
                pend_v_r <= pend_v_r;
            end

            if (apply_s) begin
                div_r    <= pend_r.div;
                en_r     <= pend_r.en;
                cnt_r    <= '0;
                tone_r   <= new_active_s;
                active_r <= new_active_s;
            end else if (running_s) begin
                cnt_r    <= cnt_next_s;
                tone_r   <= tone_next_s;
            end else begin
                cnt_r    <= '0;
                tone_r   <= 1'b0;
            end
        end
    end

    assign pend_v = pend_v_r;
    assign tone   = tone_r;
    assign active = active_r;

endmodule

// File: rtl/tone_gen_multi.sv
// Multi-channel programmable square-wave tone generator with a valid/ready
// configuration port and an OR-mixed output for the speaker stage.
module tone_gen_multi
    import tone_pkg::*;
#(
    parameter  int CH = 4,
    parameter  int DW = 16,
    localparam int CW = (CH > 1) ? $clog2(CH) : 1
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [CW-1:0] cfg_ch,
    input  logic [DW-1:0] cfg_div,
    input  logic          cfg_en,
    output logic [CH-1:0] tone,
    output logic [CH-1:0] active,
    output logic          mix_out
);

    tone_cfg_t     cfg_s;
    logic [CH-1:0] pend_v_s;
    logic [CH-1:0] wr_s;
    logic          ready_sel_s;

    // Zero-extend the incoming divisor into the shared config record.
    always_comb begin
        cfg_s          = '0;
        cfg_s.div[DW-1:0] = cfg_div;
        cfg_s.en       = cfg_en;
    end

    // Pending flag of the addressed channel; indices beyond CH always accept.
    always_comb begin
        ready_sel_s = 1'b1;
        for (int i = 0; i < CH; i++) begin
            ready_sel_s = (int'(cfg_ch) == i) ? !pend_v_s[i] : ready_sel_s;
        end
    end

    assign cfg_ready = !rst && ready_sel_s;

    generate
        for (genvar g = 0; g < CH; g++) begin : g_chan
            assign wr_s[g] = cfg_valid && cfg_ready && (int'(cfg_ch) == g);

            tone_chan #(
                .DW(DW)
            ) u_chan (
                .clk    (clk),
                .rst    (rst),
                .wr     (wr_s[g]),
                .wr_cfg (cfg_s),
                .pend_v (pend_v_s[g]),
                .tone   (tone[g]),
                .active (active[g])
            );
        end
    endgenerate

    assign mix_out = |tone;

endmodule
